// File: rtl/bank_group_arbiter_pkg.sv
// arb_pkg: shared types and helpers for the bank-group arbiter.
//   bg_state_t  - arbiter FSM state encoding
//   ARB_DEFAULT_BANKS / ARB_DEFAULT_BURST - default parameter values
//   rr_next_idx - round-robin successor of a bank index
package arb_pkg;

  typedef enum logic [1:0] {IDLE, ARB, SERVE, DONE} bg_state_t;

  localparam int ARB_DEFAULT_BANKS = 4;
  localparam int ARB_DEFAULT_BURST = 4;

  // Next bank index after idx, wrapping at num_banks.
  function automatic int rr_next_idx(input int idx, input int num_banks);
    return (idx + 1) % num_banks;
  endfunction

endpackage

// File: rtl/bank_group_arbiter_if.sv
// bank_group_arbiter_if: handshake/bus bundle between the scheduler side and
// one bank-group arbiter.
//   start, bank_req, valid, grant : scheduler/bank/group-arbiter -> arbiter
//   req, ack, sel, en, done       : arbiter -> upstream/banks/data path
//   beat_cnt, max_burst_hit       : statistics, only with BANK_ARB_STATS_EN
// Modports: slave = arbiter side, master = driving environment.
interface bank_group_arbiter_if #(
  parameter int NUM_BANKS = 4,
  parameter int SEL_W     = $clog2(NUM_BANKS)
);
  logic                 start;
  logic [NUM_BANKS-1:0] bank_req;
  logic [NUM_BANKS-1:0] valid;
  logic                 grant;
  logic                 req;
  logic [NUM_BANKS-1:0] ack;
  logic [SEL_W-1:0]     sel;
  logic                 en;
  logic                 done;
`ifdef BANK_ARB_STATS_EN
  logic [15:0]          beat_cnt;
  logic                 max_burst_hit;
`endif

  modport slave (
    input  start, bank_req, valid, grant,
`ifdef BANK_ARB_STATS_EN
    output beat_cnt, max_burst_hit,
`endif
    output req, ack, sel, en, done
  );

  modport master (
    output start, bank_req, valid, grant,
`ifdef BANK_ARB_STATS_EN
    input  beat_cnt, max_burst_hit,
`endif
    input  req, ack, sel, en, done
  );

endinterface

// File: rtl/bank_group_arbiter_picker.sv
// rr_priority_picker: combinational round-robin search.
//   req_vec : candidate banks
//   ptr     : bank with highest priority this cycle
//   found   : at least one candidate exists
//   idx     : first candidate at or after ptr, wrapping mod NUM_BANKS
module rr_priority_picker #(
  parameter int NUM_BANKS = 4,
  parameter int SEL_W     = $clog2(NUM_BANKS)
) (
  input  logic [NUM_BANKS-1:0] req_vec,
  input  logic [SEL_W-1:0]     ptr,
  output logic                 found,
  output logic [SEL_W-1:0]     idx
);

  logic [2*NUM_BANKS-1:0] dbl_vec;
  logic [NUM_BANKS-1:0]   rot_vec;
  logic [SEL_W-1:0]       offset;

  // Rotating the doubled vector right by ptr puts bank ptr at bit 0, so the
  // lowest set bit is the round-robin winner; offset is relative to ptr and
  // the SEL_W-wide add wraps back into range.
  always_comb begin
    dbl_vec = {req_vec, req_vec};
    rot_vec = NUM_BANKS'(dbl_vec >> ptr);
    found   = 1'b0;
    offset  = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (rot_vec[i]) begin
        found  = 1'b1;
        offset = SEL_W'(i);
      end
    end
    idx = ptr + offset;
  end

endmodule

// File: rtl/bank_group_arbiter.sv
// bank_group_arbiter: per-bank-group arbiter. Requests service from the
// group-level arbiter, then serves banks round-robin with bursts of at most
// BURST_MAX beats, re-arbitrating (one bubble cycle) between bursts.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - bank_group_arbiter_if.slave (start/bank_req/valid/grant in,
//           req/ack/sel/en/done out)
// Optional: define BANK_ARB_STATS_EN to add beat_cnt and max_burst_hit.
module bank_group_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_BANKS = ARB_DEFAULT_BANKS,
  parameter int SEL_W     = $clog2(NUM_BANKS),
  parameter int BURST_MAX = ARB_DEFAULT_BURST,
  parameter int CNT_W     = $clog2(BURST_MAX) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bank_group_arbiter_if.slave   bus
);

  bg_state_t            state;
  logic [SEL_W-1:0]     ptr;
  logic [SEL_W-1:0]     sel_q;
  logic [CNT_W-1:0]     cnt;
  logic                 pick_found;
  logic [SEL_W-1:0]     pick_idx;
  logic                 beat;
  logic                 burst_last;
  logic [SEL_W-1:0]     ptr_next;

  rr_priority_picker #(
    .NUM_BANKS (NUM_BANKS),
    .SEL_W     (SEL_W)
  ) u_picker (
    .req_vec (bus.bank_req & bus.valid),
    .ptr     (ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // A beat needs the selected bank to still have a ready head and the group
  // to still hold the grant; losing either ends the burst with no ack.
  always_comb begin
    beat       = (state == SERVE) && bus.bank_req[sel_q] && bus.valid[sel_q] && bus.grant;
    burst_last = beat && (cnt == CNT_W'(BURST_MAX - 1));
    ptr_next   = SEL_W'(rr_next_idx(int'(sel_q), NUM_BANKS));
    bus.ack    = '0;
    if (beat) begin
      bus.ack[sel_q] = 1'b1;
    end
  end

  assign bus.en   = beat;
  assign bus.sel  = sel_q;
  assign bus.req  = (state == ARB) || (state == SERVE);
  assign bus.done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      sel_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && (|bus.bank_req)) begin
            state <= ARB;
          end
        end
        ARB: begin
          if (bus.grant) begin
            if (pick_found) begin
              sel_q <= pick_idx;
              cnt   <= '0;
              state <= SERVE;
            end else if (bus.bank_req == '0) begin
              state <= DONE;
            end
          end
        end
        SERVE: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
          end
          if (!beat || burst_last) begin
            ptr   <= ptr_next;
            state <= ARB;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BANK_ARB_STATS_EN
  logic [15:0] beat_cnt_q;

  // Saturating beat counter, cleared when the round completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (state == DONE) begin
      beat_cnt_q <= '0;
    end else if (beat && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

  assign bus.beat_cnt      = beat_cnt_q;
  assign bus.max_burst_hit = burst_last;
`endif

endmodule

// File: doc/bank_group_arbiter.md
Name: bank_group_arbiter

Overview:
- Parametrised per-bank-group arbiter for the back-end memory scheduler.
- Collects requests from NUM_BANKS bank queues and requests service from the group-level arbiter.
- Once granted, serves banks round-robin with a bounded burst per bank, driving the bank select and write enable of the downstream data path.
- Successor to the fixed 4-bank group FSM: bank count and burst length are parametrised, it adds a grant handshake and fair rotation, and it reports when the group is done.

Parameters:
- NUM_BANKS, 4, number of bank queues in the group (power of two, >=2).
- SEL_W, $clog2(NUM_BANKS), width of the bank select.
- BURST_MAX, 4, maximum consecutive acks to one bank before rotating (>=1).
- CNT_W, $clog2(BURST_MAX)+1, width of the burst counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, scheduler enables a service round (level).
- bank_req, input, NUM_BANKS, bank queue non-empty.
- valid, input, NUM_BANKS, bank head entry ready to issue.
- grant, input, 1, group-level arbiter grants this group.
- req, output, 1, group requests service upward.
- ack, output, NUM_BANKS, one-hot pop strobe to the served bank.
- sel, output, SEL_W, bank select to the data path mux.
- en, output, 1, write enable to downstream (one beat per cycle).
- done, output, 1, one-cycle pulse: round finished.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, ptr=0, sel=0, burst cnt=0, req=0, done=0, ack=0, en=0.
- States: IDLE, ARB, SERVE, DONE. State, ptr, sel and cnt are registered. req and done decode from state. ack and en are combinational.
- IDLE:
  - If start=1 and |bank_req, go to ARB next cycle.
  - Otherwise stay in IDLE.
- ARB:
  - req=1.
  - If grant=1, search from ptr upward with wrap mod NUM_BANKS for the first bank i with bank_req[i]&valid[i]. If found, sel<=i, cnt<=0, go to SERVE.
  - If grant=1 and bank_req==0, go to DONE.
  - Otherwise (no grant, or requests pending but none valid) stay in ARB.
- SERVE:
  - req=1.
  - en = ack[sel] = bank_req[sel] & valid[sel] & grant. All other ack bits are 0.
  - Each acked cycle increments cnt.
  - Leave to ARB with ptr<=(sel+1) mod NUM_BANKS when any of the following holds:
    - an ack occurs with cnt==BURST_MAX-1;
    - valid[sel]=0 or bank_req[sel]=0;
    - grant=0, in which case no ack is given that cycle.
  - Re-arbitration costs one bubble cycle in ARB. Max throughput is BURST_MAX beats per BURST_MAX+1 cycles.
- DONE: done=1 and req=0 for exactly one cycle, then IDLE.
- start deasserting mid-round has no effect. The round ends only through DONE.
- Simultaneous events: in ARB, if the only requesting bank is at ptr, it is selected, so a single bank is never blocked by rotation.
- Wrap-around: ptr and the search index are SEL_W wide and wrap naturally from NUM_BANKS-1 to 0.
- Reset mid-operation forces IDLE immediately. ack and en drop asynchronously with the state.
- ack is never asserted for more than one bank. ack never asserts outside SERVE.

Optional Feature:
- Macro: BANK_ARB_STATS_EN.
- When defined, adds output beat_cnt[15:0] and output max_burst_hit (1-cycle pulse).
  - beat_cnt counts en cycles and saturates at 16'hFFFF. It is cleared on reset and on the done pulse.
  - max_burst_hit pulses when a rotation is caused by the cnt==BURST_MAX-1 limit.
- When undefined, these ports and registers are absent and the core behaviour is identical.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARB, SERVE, DONE} bg_state_t;
  - constants ARB_DEFAULT_BANKS=4 and ARB_DEFAULT_BURST=4;
  - function rr_next_idx(), used by both the RTL and the bench model.
- One sub-module, rr_priority_picker (NUM_BANKS, SEL_W): combinational.
  - Inputs: request vector and ptr.
  - Outputs: found and idx. It uses a doubled-vector rotate search.

Test Plan (NUM_BANKS=4, BURST_MAX=2 unless stated):
- Reset: hold rst_n=0 with bank_req=4'b1111 and start=1 -> req=0, ack=0, en=0, sel=0. Release rst_n -> req=1 one cycle later.
- All banks valid, grant tied to 1 -> ack sequence 0001,0001,-,0010,0010,-,0100,0100,-,1000,1000 with a bubble (-) each rotation; sel follows 0,1,2,3.
- Only bank 2 requesting with valid=4'b0100 for 5 beats, then bank_req cleared -> acks to bank 2 in bursts of 2 with bubbles; then DONE: done=1 for one cycle and req=0.
- Grant dropped for 3 cycles during SERVE -> no ack or en while grant=0; state returns to ARB; ptr advances; service resumes on the next bank once grant returns.
- bank_req=4'b0011 with valid=0 -> stays in ARB with req=1 and no acks indefinitely. Setting valid[1]=1 starts serving bank 1 on the next cycle.
- NUM_BANKS=8, BURST_MAX=1, all valid -> ack one-hot rotates 0..7 and wraps to 0. With BANK_ARB_STATS_EN, beat_cnt=8 after the first rotation and max_burst_hit pulses on every beat.
